filter_scheduler: RTL and testbench
===================================

FILTER_SCHEDULER -- requirements
Module: filter_scheduler

Interface
REQ-001 SHALL have parameter NUM_FILTERS, default 4: number of filter modes cycled, 2..8.
REQ-002 SHALL have parameter BEATS_PER_SWITCH, default 4: beats per filter change, 1..15.
REQ-003 SHALL have parameter FLASH_STEP, default 32: flash decay per frame, 1..255.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port bpm_in, input, 9 bits: tempo estimate, unsigned BPM.
REQ-007 SHALL have port beat_pulse, input, 1 bit: beat indication, may be held high for several cycles.
REQ-008 SHALL have port frame_end, input, 1 bit: single-cycle pulse when the last pixel of a frame is accepted (endofpacket & valid & ready).
REQ-009 SHALL have port filter_sel, output, $clog2(NUM_FILTERS) bits: active filter index.
REQ-010 SHALL have port tempo_band, output, 2 bits: tempo class.
REQ-011 SHALL have port flash_level, output, 8 bits: beat brightness boost.
REQ-012 SHALL have port switch_pending, output, 1 bit: a filter change is armed.

Function
REQ-013 SHALL register all outputs; none SHALL depend combinationally on inputs.
REQ-014 SHALL detect beats as rising edges of beat_pulse using a registered previous value; a held-high pulse counts once.
REQ-015 SHALL run a state machine with states IDLE, RUN and ARMED.
REQ-016 SHALL enter IDLE from any state when bpm_in == 0, clear beat_cnt and switch_pending there, and ignore beat edges.
REQ-017 SHALL go IDLE -> RUN on the first cycle bpm_in != 0.
REQ-018 SHALL, in RUN, increment beat_cnt on each beat edge; on the edge that makes beat_cnt reach BEATS_PER_SWITCH it SHALL reset beat_cnt to 0, set switch_pending and go to ARMED.
REQ-019 SHALL, in ARMED, keep counting beats into beat_cnt but SHALL NOT re-arm; extra completed groups are discarded.
REQ-020 SHALL, on frame_end in ARMED, set filter_sel to filter_sel+1, wrapping NUM_FILTERS-1 -> 0, clear switch_pending and return to RUN.
REQ-021 SHALL NOT apply an arm in the cycle it is created: if a group completes in the same cycle as frame_end, the switch SHALL apply at the next frame_end.
REQ-022 SHALL change filter_sel only on frame_end; it holds through IDLE.
REQ-023 SHALL latch tempo_band only on frame_end: bpm_in < 90 -> 0; 90..129 -> 1; 130..169 -> 2; >= 170 -> 3.
REQ-024 SHALL set a flash_req flag on any beat edge outside IDLE.
REQ-025 SHALL, on frame_end with flash_req set, load flash_level = 255 and clear flash_req.
REQ-026 SHALL, on frame_end without flash_req, decrease flash_level by FLASH_STEP, saturating at 0.
REQ-027 SHALL give a beat edge coincident with frame_end to flash_req for the next frame_end, not the current one.
REQ-028 SHALL NOT change flash_level between frame_end pulses.

Reset
REQ-029 SHALL, on reset, set filter_sel=0, tempo_band=0, flash_level=0, switch_pending=0, beat_cnt=0, flash_req=0, state IDLE, and the previous-beat register to 1.
REQ-030 SHALL give reset priority over all inputs, including reset mid-ARMED with frame_end high.

Verification
REQ-031 SHALL cover: bpm_in=120, 4 one-cycle beats, then frame_end -> switch_pending high after 4th beat; filter_sel 0->1 the cycle after frame_end; tempo_band=1.
REQ-032 SHALL cover: 4 groups of 4 beats, each followed by a frame_end, NUM_FILTERS=4 -> filter_sel sequence 1,2,3,0.
REQ-033 SHALL cover: 4th beat edge in the same cycle as frame_end -> filter_sel unchanged; it increments at the following frame_end.
REQ-034 SHALL cover: beat then frame_end, then 3 frame_ends with no beats, FLASH_STEP=32 -> flash_level 255, 223, 191, 159.
REQ-035 SHALL cover: beat_pulse held high 20 cycles -> one beat counted; bpm_in=0 mid-ARMED -> switch_pending cleared, next frame_end leaves filter_sel unchanged.
REQ-036 SHALL cover: reset asserted in ARMED with frame_end high -> all outputs at REQ-029 values the next cycle.

Source files
------------

// File: rtl/filter_scheduler_if.sv
// Bundle of the tempo/beat inputs and scheduler outputs shared by the scheduler and its driver.
interface filter_scheduler_if #(
    parameter int NUM_FILTERS = 4
) ();
    localparam int SelW = $clog2(NUM_FILTERS);

    logic [8:0]      bpm_in;
    logic            beat_pulse;
    logic            frame_end;
    logic [SelW-1:0] filter_sel;
    logic [1:0]      tempo_band;
    logic [7:0]      flash_level;
    logic            switch_pending;

    // Driver side: supplies tempo, beats and frame timing; observes scheduler outputs.
    modport master (
        output bpm_in, beat_pulse, frame_end,
        input  filter_sel, tempo_band, flash_level, switch_pending
    );

    // Scheduler side.
    modport slave (
        input  bpm_in, beat_pulse, frame_end,
        output filter_sel, tempo_band, flash_level, switch_pending
    );
endinterface

// File: rtl/filter_scheduler.sv
// Beat-synchronised filter scheduler: counts beats into groups, arms a filter change per group
// and applies it at the next frame boundary; also tracks tempo class and a decaying beat flash.
module filter_scheduler #(
    parameter int NUM_FILTERS      = 4,
    parameter int BEATS_PER_SWITCH = 4,
    parameter int FLASH_STEP       = 32
) (
    input logic              clk,
    input logic              reset,
    filter_scheduler_if.slave bus
);
    localparam int SelW = $clog2(NUM_FILTERS);

    typedef enum logic [1:0] {StIdle, StRun, StArmed} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic [SelW-1:0] sel_q, sel_d;
    logic [1:0]      band_q, band_d;
    logic [7:0]      flash_q, flash_d;
    logic            flash_req_q, flash_req_d;
    logic            beat_prev_q;

    logic            bpm_zero;
    logic            live_edge;
    logic [3:0]      cnt_inc;
    logic            group_done;

    // Beat edges only count while a tempo is present and the scheduler is not idle.
    assign bpm_zero   = (bus.bpm_in == 9'd0);
    assign live_edge  = bus.beat_pulse & ~beat_prev_q & ~bpm_zero & (state_q != StIdle);
    assign cnt_inc    = cnt_q + 4'd1;
    assign group_done = (cnt_inc == 4'(BEATS_PER_SWITCH));

    // Group counting, arming and filter switching state machine.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        sel_d   = sel_q;
        if (bpm_zero) begin
            state_d = StIdle;
            cnt_d   = 4'd0;
            pend_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StRun;
                StRun: begin
                    // frame_end is ignored here, so an arm made this cycle waits for the next one.
                    if (live_edge) begin
                        if (group_done) begin
                            cnt_d   = 4'd0;
                            pend_d  = 1'b1;
                            state_d = StArmed;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                StArmed: begin
                    // Completed groups while armed are dropped rather than queued.
                    if (live_edge) cnt_d = group_done ? 4'd0 : cnt_inc;
                    if (bus.frame_end) begin
                        sel_d   = (sel_q == SelW'(NUM_FILTERS - 1)) ? '0 : sel_q + 1'b1;
                        pend_d  = 1'b0;
                        state_d = StRun;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Frame-boundary updates of tempo class and flash brightness.
    always_comb begin
        band_d      = band_q;
        flash_d     = flash_q;
        flash_req_d = flash_req_q | live_edge;
        if (bus.frame_end) begin
            if (bus.bpm_in < 9'd90)       band_d = 2'd0;
            else if (bus.bpm_in < 9'd130) band_d = 2'd1;
            else if (bus.bpm_in < 9'd170) band_d = 2'd2;
            else                          band_d = 2'd3;
            if (flash_req_q) begin
                flash_d = 8'd255;
            end else if ({1'b0, flash_q} < 9'(FLASH_STEP)) begin
                flash_d = 8'd0;
            end else begin
                flash_d = flash_q - 8'(FLASH_STEP);
            end
            // A beat on the frame_end cycle feeds the following frame, not this one.
            flash_req_d = live_edge;
        end
    end

    // State registers; synchronous reset has priority over every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            pend_q      <= 1'b0;
            sel_q       <= '0;
            band_q      <= 2'd0;
            flash_q     <= 8'd0;
            flash_req_q <= 1'b0;
            beat_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            sel_q       <= sel_d;
            band_q      <= band_d;
            flash_q     <= flash_d;
            flash_req_q <= flash_req_d;
            beat_prev_q <= bus.beat_pulse;
        end
    end

    assign bus.filter_sel     = sel_q;
    assign bus.tempo_band     = band_q;
    assign bus.flash_level    = flash_q;
    assign bus.switch_pending = pend_q;
endmodule

// File: tb/tb_filter_scheduler.sv
// Directed bench for filter_scheduler: a per-cycle vector table plus hand-written sequences.
module tb_filter_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;

    filter_scheduler_if #(.NUM_FILTERS(4)) bus ();

    filter_scheduler #(
        .NUM_FILTERS(4),
        .BEATS_PER_SWITCH(4),
        .FLASH_STEP(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [8:0] bpm;
        logic       beat;
        logic       fe;
        logic [1:0] sel;
        logic [1:0] band;
        logic [7:0] flash;
        logic       pend;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Apply one cycle of inputs and sample outputs 1 time unit after the rising edge.
    task automatic cyc(input logic r, input logic [8:0] b, input logic bt, input logic f);
        reset          = r;
        bus.bpm_in     = b;
        bus.beat_pulse = bt;
        bus.frame_end  = f;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input logic [1:0] s, input logic [1:0] bd,
                           input logic [7:0] fl, input logic p);
        n_vec++;
        if (bus.filter_sel !== s || bus.tempo_band !== bd || bus.flash_level !== fl ||
            bus.switch_pending !== p) begin
            n_err++;
            $display("FAIL %s: got sel=%0d band=%0d flash=%0d pend=%0d, want sel=%0d band=%0d flash=%0d pend=%0d",
                     name, bus.filter_sel, bus.tempo_band, bus.flash_level, bus.switch_pending,
                     s, bd, fl, p);
        end
    endtask

    task automatic chk_sp(input string name, input logic [1:0] s, input logic p);
        n_vec++;
        if (bus.filter_sel !== s || bus.switch_pending !== p) begin
            n_err++;
            $display("FAIL %s: got sel=%0d pend=%0d, want sel=%0d pend=%0d",
                     name, bus.filter_sel, bus.switch_pending, s, p);
        end
    endtask

    task automatic pulse(input logic [8:0] b);
        cyc(1'b0, b, 1'b1, 1'b0);
        cyc(1'b0, b, 1'b0, 1'b0);
    endtask

    initial begin
        bus.bpm_in     = 9'd0;
        bus.beat_pulse = 1'b0;
        bus.frame_end  = 1'b0;

        //             rst  bpm   beat fe   sel band flash pend
        tbl.push_back('{1'b1, 9'd0,   1'b0, 1'b0, 2'd0, 2'd0, 8'd0,   1'b0}); // reset
        tbl.push_back('{1'b0, 9'd120, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0,   1'b0}); // idle->run
        tbl.push_back('{1'b0, 9'd120, 1'b1, 1'b0, 2'd0, 2'd0, 8'd0,   1'b0}); // beat 1
        tbl.push_back('{1'b0, 9'd120, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0,   1'b0});
        tbl.push_back('{1'b0, 9'd120, 1'b1, 1'b0, 2'd0, 2'd0, 8'd0,   1'b0}); // beat 2
        tbl.push_back('{1'b0, 9'd120, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0,   1'b0});
        tbl.push_back('{1'b0, 9'd120, 1'b1, 1'b0, 2'd0, 2'd0, 8'd0,   1'b0}); // beat 3
        tbl.push_back('{1'b0, 9'd120, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0,   1'b0});
        tbl.push_back('{1'b0, 9'd120, 1'b1, 1'b0, 2'd0, 2'd0, 8'd0,   1'b1}); // beat 4 arms
        tbl.push_back('{1'b0, 9'd120, 1'b0, 1'b1, 2'd1, 2'd1, 8'd255, 1'b0}); // switch + flash
        tbl.push_back('{1'b0, 9'd120, 1'b0, 1'b0, 2'd1, 2'd1, 8'd255, 1'b0}); // flash holds
        tbl.push_back('{1'b0, 9'd120, 1'b0, 1'b1, 2'd1, 2'd1, 8'd223, 1'b0});
        tbl.push_back('{1'b0, 9'd120, 1'b0, 1'b0, 2'd1, 2'd1, 8'd223, 1'b0});
        tbl.push_back('{1'b0, 9'd120, 1'b0, 1'b1, 2'd1, 2'd1, 8'd191, 1'b0});
        tbl.push_back('{1'b0, 9'd120, 1'b0, 1'b0, 2'd1, 2'd1, 8'd191, 1'b0});
        tbl.push_back('{1'b0, 9'd120, 1'b0, 1'b1, 2'd1, 2'd1, 8'd159, 1'b0});
        tbl.push_back('{1'b0, 9'd120, 1'b1, 1'b0, 2'd1, 2'd1, 8'd159, 1'b0}); // beat 1
        tbl.push_back('{1'b0, 9'd120, 1'b0, 1'b0, 2'd1, 2'd1, 8'd159, 1'b0});
        tbl.push_back('{1'b0, 9'd120, 1'b1, 1'b0, 2'd1, 2'd1, 8'd159, 1'b0}); // beat 2
        tbl.push_back('{1'b0, 9'd120, 1'b0, 1'b0, 2'd1, 2'd1, 8'd159, 1'b0});
        tbl.push_back('{1'b0, 9'd120, 1'b1, 1'b0, 2'd1, 2'd1, 8'd159, 1'b0}); // beat 3
        tbl.push_back('{1'b0, 9'd120, 1'b0, 1'b0, 2'd1, 2'd1, 8'd159, 1'b0});
        tbl.push_back('{1'b0, 9'd120, 1'b1, 1'b1, 2'd1, 2'd1, 8'd255, 1'b1}); // beat 4 on frame_end
        tbl.push_back('{1'b0, 9'd120, 1'b0, 1'b0, 2'd1, 2'd1, 8'd255, 1'b1});
        tbl.push_back('{1'b0, 9'd150, 1'b0, 1'b1, 2'd2, 2'd2, 8'd255, 1'b0}); // deferred switch
        tbl.push_back('{1'b0, 9'd89,  1'b0, 1'b0, 2'd2, 2'd2, 8'd255, 1'b0}); // band not latched
        tbl.push_back('{1'b0, 9'd89,  1'b0, 1'b1, 2'd2, 2'd0, 8'd223, 1'b0});
        tbl.push_back('{1'b0, 9'd90,  1'b0, 1'b1, 2'd2, 2'd1, 8'd191, 1'b0});
        tbl.push_back('{1'b0, 9'd129, 1'b0, 1'b1, 2'd2, 2'd1, 8'd159, 1'b0});
        tbl.push_back('{1'b0, 9'd130, 1'b0, 1'b1, 2'd2, 2'd2, 8'd127, 1'b0});
        tbl.push_back('{1'b0, 9'd169, 1'b0, 1'b1, 2'd2, 2'd2, 8'd95,  1'b0});
        tbl.push_back('{1'b0, 9'd170, 1'b0, 1'b1, 2'd2, 2'd3, 8'd63,  1'b0});
        tbl.push_back('{1'b0, 9'd511, 1'b0, 1'b1, 2'd2, 2'd3, 8'd31,  1'b0});
        tbl.push_back('{1'b0, 9'd300, 1'b0, 1'b1, 2'd2, 2'd3, 8'd0,   1'b0}); // saturate at 0
        tbl.push_back('{1'b0, 9'd300, 1'b0, 1'b1, 2'd2, 2'd3, 8'd0,   1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].bpm, tbl[i].beat, tbl[i].fe);
            chk_all($sformatf("vec%0d", i), tbl[i].sel, tbl[i].band, tbl[i].flash, tbl[i].pend);
        end

        // Four groups of four beats, each followed by frame_end: filter_sel 1,2,3,0.
        cyc(1'b1, 9'd0, 1'b0, 1'b0);
        cyc(1'b0, 9'd120, 1'b0, 1'b0);
        for (int g = 0; g < 4; g++) begin
            for (int b = 0; b < 4; b++) pulse(9'd120);
            chk_sp($sformatf("grp%0d_armed", g), 2'(g), 1'b1);
            cyc(1'b0, 9'd120, 1'b0, 1'b1);
            chk_sp($sformatf("grp%0d_switch", g), 2'((g + 1) % 4), 1'b0);
        end

        // Beat held high for 20 cycles counts once; three more beats complete the group.
        for (int c = 0; c < 20; c++) cyc(1'b0, 9'd120, 1'b1, 1'b0);
        cyc(1'b0, 9'd120, 1'b0, 1'b0);
        pulse(9'd120);
        pulse(9'd120);
        chk_sp("held_beat_once", 2'd0, 1'b0);
        pulse(9'd120);
        chk_sp("held_then_armed", 2'd0, 1'b1);
        // Tempo loss while armed drops the arm; later frame_ends leave filter_sel alone.
        cyc(1'b0, 9'd0, 1'b0, 1'b0);
        chk_sp("bpm0_clears_pend", 2'd0, 1'b0);
        cyc(1'b0, 9'd120, 1'b0, 1'b1);
        cyc(1'b0, 9'd120, 1'b0, 1'b0);
        cyc(1'b0, 9'd120, 1'b0, 1'b1);
        chk_sp("bpm0_no_switch", 2'd0, 1'b0);

        // Reset while armed with frame_end (and a beat edge) high.
        for (int b = 0; b < 4; b++) pulse(9'd120);
        cyc(1'b0, 9'd120, 1'b0, 1'b1);
        chk_all("pre_reset_switch", 2'd1, 2'd1, 8'd255, 1'b0);
        for (int b = 0; b < 4; b++) pulse(9'd120);
        chk_sp("pre_reset_armed", 2'd1, 1'b1);
        cyc(1'b1, 9'd120, 1'b1, 1'b1);
        chk_all("reset_in_armed", 2'd0, 2'd0, 8'd0, 1'b0);
        // flash_req must have been cleared by reset, so this frame_end only decays from 0.
        cyc(1'b0, 9'd120, 1'b0, 1'b1);
        chk_all("post_reset_frame", 2'd0, 2'd1, 8'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
